// File: rtl/kfmmc_block_write_sequencer.sv
// Writes a run of 512-byte pattern blocks to the card through the
// KFMMC_Drive register strobes; all state advances on the falling clock edge.
module kfmmc_block_write_sequencer #(
    parameter logic [7:0]  WRITE_COMMAND = 8'hC0,
    parameter logic [7:0]  SEED          = 8'h5A,
    parameter logic [31:0] TIMEOUT       = 32'h000FFFF0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] base_block,
    input  logic [7:0]  block_count,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  error_code,
    output logic [7:0]  blocks_written,
    output logic [7:0]  internal_data_bus,
    output logic        write_block_address_1,
    output logic        write_block_address_2,
    output logic        write_block_address_3,
    output logic        write_block_address_4,
    output logic        write_access_command,
    output logic        write_data,
    input  logic        drive_busy,
    input  logic        block_write_interrupt,
    input  logic        write_completion_interrupt,
    input  logic        write_interface_error,
    input  logic        write_crc_error
);

    typedef enum logic [3:0] {
        IDLE,
        WAIT_READY,
        ADDR_1,
        ADDR_2,
        ADDR_3,
        ADDR_4,
        COMMAND,
        WAIT_REQ,
        SEND_BYTE,
        WAIT_COMPLETE,
        NEXT_BLOCK,
        DONE,
        ERROR
    } state_t;

    state_t      state;
    state_t      state_d;
    logic [1:0]  code_d;
    logic [31:0] current_block;
    logic [7:0]  count_latched;
    logic [8:0]  byte_index;
    logic [31:0] timer;
    logic        busy_state;
    logic        waiting;
    logic        timed_out;

    always_comb begin
        busy_state = !(state inside {IDLE, DONE, ERROR});
        waiting    = state inside {WAIT_READY, WAIT_REQ, WAIT_COMPLETE};
        timed_out  = waiting && (timer >= TIMEOUT - 32'd1);
    end

    // A drive error in any busy state wins over every other transition.
    always_comb begin
        state_d = state;
        code_d  = error_code;
        if (busy_state && (write_crc_error || write_interface_error)) begin
            state_d = ERROR;
            code_d  = write_crc_error ? 2'b10 : 2'b01;
        end else begin
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state_d = (block_count == 8'd0) ? DONE : WAIT_READY;
                        code_d  = 2'b00;
                    end
                end
                WAIT_READY: begin
                    if (!drive_busy) begin
                        state_d = ADDR_1;
                    end else if (timed_out) begin
                        state_d = ERROR;
                        code_d  = 2'b11;
                    end
                end
                ADDR_1:  state_d = ADDR_2;
                ADDR_2:  state_d = ADDR_3;
                ADDR_3:  state_d = ADDR_4;
                ADDR_4:  state_d = COMMAND;
                COMMAND: state_d = WAIT_REQ;
                WAIT_REQ: begin
                    if (block_write_interrupt) begin
                        state_d = SEND_BYTE;
                    end else if (timed_out) begin
                        state_d = ERROR;
                        code_d  = 2'b11;
                    end
                end
                SEND_BYTE: begin
                    state_d = (byte_index == 9'd511) ? WAIT_COMPLETE : WAIT_REQ;
                end
                WAIT_COMPLETE: begin
                    if (write_completion_interrupt) begin
                        state_d = NEXT_BLOCK;
                    end else if (timed_out) begin
                        state_d = ERROR;
                        code_d  = 2'b11;
                    end
                end
                NEXT_BLOCK: begin
                    if (blocks_written + 8'd1 == count_latched) begin
                        state_d = DONE;
                    end else begin
                        state_d = WAIT_READY;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same
    // edge the state does.
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            state                 <= IDLE;
            error_code            <= 2'b00;
            current_block         <= 32'd0;
            count_latched         <= 8'd0;
            byte_index            <= 9'd0;
            timer                 <= 32'd0;
            blocks_written        <= 8'd0;
            busy                  <= 1'b0;
            done                  <= 1'b0;
            error                 <= 1'b0;
            internal_data_bus     <= 8'h00;
            write_block_address_1 <= 1'b0;
            write_block_address_2 <= 1'b0;
            write_block_address_3 <= 1'b0;
            write_block_address_4 <= 1'b0;
            write_access_command  <= 1'b0;
            write_data            <= 1'b0;
        end else begin
            state      <= state_d;
            error_code <= code_d;

            if (state_d != state) begin
                timer <= 32'd0;
            end else if (waiting) begin
                timer <= timer + 32'd1;
            end

            if (!busy_state && start) begin
                current_block  <= base_block;
                count_latched  <= block_count;
                blocks_written <= 8'd0;
                byte_index     <= 9'd0;
            end

            if (state == SEND_BYTE && state_d != ERROR) begin
                byte_index <= byte_index + 9'd1;
            end

            if (state == NEXT_BLOCK && state_d != ERROR) begin
                blocks_written <= blocks_written + 8'd1;
                current_block  <= current_block + 32'd1;
                byte_index     <= 9'd0;
            end

            busy                  <= !(state_d inside {IDLE, DONE, ERROR});
            done                  <= (state_d == DONE);
            error                 <= (state_d == ERROR);
            internal_data_bus     <= 8'h00;
            write_block_address_1 <= 1'b0;
            write_block_address_2 <= 1'b0;
            write_block_address_3 <= 1'b0;
            write_block_address_4 <= 1'b0;
            write_access_command  <= 1'b0;
            write_data            <= 1'b0;

            case (state_d)
                ADDR_1: begin
                    internal_data_bus     <= current_block[7:0];
                    write_block_address_1 <= 1'b1;
                end
                ADDR_2: begin
                    internal_data_bus     <= current_block[15:8];
                    write_block_address_2 <= 1'b1;
                end
                ADDR_3: begin
                    internal_data_bus     <= current_block[23:16];
                    write_block_address_3 <= 1'b1;
                end
                ADDR_4: begin
                    internal_data_bus     <= current_block[31:24];
                    write_block_address_4 <= 1'b1;
                end
                COMMAND: begin
                    internal_data_bus    <= WRITE_COMMAND;
                    write_access_command <= 1'b1;
                end
                SEND_BYTE: begin
                    internal_data_bus <= byte_index[7:0] ^ current_block[7:0] ^ SEED;
                    write_data        <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_kfmmc_block_write_sequencer.sv
// Randomised drive model around the write sequencer; every strobe is
// compared with a block/byte stream built from the pattern rule.
module tb_kfmmc_block_write_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] base_block;
    logic [7:0]  block_count;
    logic        busy, done, error;
    logic [1:0]  error_code;
    logic [7:0]  blocks_written;
    logic [7:0]  internal_data_bus;
    logic        write_block_address_1, write_block_address_2;
    logic        write_block_address_3, write_block_address_4;
    logic        write_access_command, write_data;
    logic        drive_busy;
    logic        block_write_interrupt;
    logic        write_completion_interrupt;
    logic        write_interface_error;
    logic        write_crc_error;

    int vectors = 0;
    int miscompares = 0;

    kfmmc_block_write_sequencer #(
        .WRITE_COMMAND (8'hC0),
        .SEED          (8'h5A),
        .TIMEOUT       (32'd16)
    ) dut (
        .clock                      (clock),
        .reset                      (reset),
        .start                      (start),
        .base_block                 (base_block),
        .block_count                (block_count),
        .busy                       (busy),
        .done                       (done),
        .error                      (error),
        .error_code                 (error_code),
        .blocks_written             (blocks_written),
        .internal_data_bus          (internal_data_bus),
        .write_block_address_1      (write_block_address_1),
        .write_block_address_2      (write_block_address_2),
        .write_block_address_3      (write_block_address_3),
        .write_block_address_4      (write_block_address_4),
        .write_access_command       (write_access_command),
        .write_data                 (write_data),
        .drive_busy                 (drive_busy),
        .block_write_interrupt      (block_write_interrupt),
        .write_completion_interrupt (write_completion_interrupt),
        .write_interface_error      (write_interface_error),
        .write_crc_error            (write_crc_error)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] strobes();
        return {write_block_address_1, write_block_address_2,
                write_block_address_3, write_block_address_4,
                write_access_command, write_data};
    endfunction

    task automatic check_quiet(input string pfx);
        check({pfx, "_busy"}, 32'(busy), 0);
        check({pfx, "_done"}, 32'(done), 0);
        check({pfx, "_error"}, 32'(error), 0);
        check({pfx, "_code"}, 32'(error_code), 0);
        check({pfx, "_written"}, 32'(blocks_written), 0);
        check({pfx, "_bus"}, 32'(internal_data_bus), 0);
        check({pfx, "_strobes"}, 32'(strobes()), 0);
    endtask

    // err_kind: 0 none, 1 crc, 2 interface, 3 both; indices are in block 0
    task automatic run(input logic [31:0] base, input logic [7:0] cnt,
                       input int err_kind, input int err_at,
                       input bit no_cmpl, input int rst_at,
                       input bit restart_mid);
        logic [10:0] exp_q[$];
        logic [31:0] blk;
        logic [5:0]  s;
        logic [2:0]  kind;
        logic [7:0]  pat;
        int obs_n = 0, it = 0, bytes_blk = 0, blk_n = 0;
        int req_wait = -1, cmpl_wait = -1, busy_cycles = 0;
        int last_data_it = 0, quiet = 0;
        bit cmpl_pulse = 0, err_pulse = 0, restarted = 0;
        bit finished = 0, was_reset = 0;

        for (int k = 0; k < int'(cnt); k++) begin
            blk = base + 32'(k);
            for (int a = 0; a < 4; a++) exp_q.push_back({3'(a + 1), blk[8*a +: 8]});
            exp_q.push_back({3'd5, 8'hC0});
            for (int i = 0; i < 512; i++) begin
                pat = 8'(i) ^ blk[7:0] ^ 8'h5A;
                exp_q.push_back({3'd6, pat});
            end
        end

        @(posedge clock);
        base_block  = base;
        block_count = cnt;
        drive_busy  = 0;
        start       = 1;

        while (!finished) begin
            @(posedge clock);
            it++;
            s = strobes();
            start = 0;
            if (error || done) begin
                finished = 1;
            end else if (it > 20000) begin
                check("run_budget", 32'(it), 20000);
                finished = 1;
            end else begin
                if (busy_cycles > 0) begin
                    busy_cycles--;
                    drive_busy = (busy_cycles != 0);
                end
                if (cmpl_pulse) begin
                    write_completion_interrupt = 0;
                    cmpl_pulse = 0;
                    busy_cycles = $urandom_range(0, 3);
                    drive_busy = (busy_cycles != 0);
                end
                if (err_pulse) begin
                    write_crc_error = 0;
                    write_interface_error = 0;
                    err_pulse = 0;
                end
                check("one_hot", 32'($countones(s) <= 1), 1);
                if (s == 6'd0) check("idle_bus", 32'(internal_data_bus), 0);
                if (s != 6'd0) begin
                    case (1'b1)
                        s[5]: kind = 3'd1;
                        s[4]: kind = 3'd2;
                        s[3]: kind = 3'd3;
                        s[2]: kind = 3'd4;
                        s[1]: kind = 3'd5;
                        default: kind = 3'd6;
                    endcase
                    if (obs_n < exp_q.size())
                        check("strobe", 32'({kind, internal_data_bus}), 32'(exp_q[obs_n]));
                    else
                        check("extra_strobe", 32'(obs_n), 32'(exp_q.size()));
                    if (obs_n == 0) check("addr1_latency", 32'(it), 2);
                    if (obs_n == 4) check("cmd_latency", 32'(it), 6);
                    blk_n = obs_n / 517;
                    obs_n++;
                    if (kind == 3'd5) begin
                        bytes_blk = 0;
                        req_wait = $urandom_range(0, 3);
                    end
                    if (kind == 3'd6) begin
                        block_write_interrupt = 0;
                        last_data_it = it;
                        if (blk_n == 0 && bytes_blk == rst_at) begin
                            reset = 1;
                            #1;
                            check_quiet("mid_reset");
                            was_reset = 1;
                            finished = 1;
                        end
                        if (blk_n == 0 && bytes_blk == err_at && err_kind != 0) begin
                            write_crc_error = (err_kind != 2);
                            write_interface_error = (err_kind != 1);
                            err_pulse = 1;
                        end
                        bytes_blk++;
                        if (bytes_blk == 512) begin
                            if (!no_cmpl) cmpl_wait = $urandom_range(1, 3);
                        end else begin
                            req_wait = $urandom_range(0, 3);
                        end
                    end
                end
                if (req_wait == 0) begin
                    block_write_interrupt = 1;
                    req_wait = -1;
                end else if (req_wait > 0) begin
                    req_wait--;
                end
                if (cmpl_wait == 0) begin
                    write_completion_interrupt = 1;
                    cmpl_pulse = 1;
                    cmpl_wait = -1;
                end else if (cmpl_wait > 0) begin
                    cmpl_wait--;
                end
                if (restart_mid && !restarted && obs_n == 10) begin
                    start = 1;
                    base_block = $urandom;
                    block_count = 8'($urandom_range(1, 255));
                    restarted = 1;
                end
            end
        end

        start = 0;
        drive_busy = 0;
        block_write_interrupt = 0;
        write_completion_interrupt = 0;
        write_crc_error = 0;
        write_interface_error = 0;

        if (was_reset) begin
            @(posedge clock);
            reset = 0;
        end else if (no_cmpl) begin
            check("timeout_error", 32'(error), 1);
            check("timeout_code", 32'(error_code), 3);
            check("timeout_clocks", 32'(it - last_data_it), 17);
            check("timeout_strobes", 32'(obs_n), 32'(exp_q.size()));
        end else if (err_kind != 0) begin
            check("err_flag", 32'(error), 1);
            check("err_busy", 32'(busy), 0);
            check("err_code", 32'(error_code), (err_kind == 2) ? 1 : 2);
            check("err_strobes", 32'(obs_n), 32'(6 + err_at));
            check("err_written", 32'(blocks_written), 0);
            repeat (20) begin
                @(posedge clock);
                if (strobes() != 6'd0 || internal_data_bus != 8'h00) quiet++;
            end
            check("post_err_quiet", 32'(quiet), 0);
            check("err_hold", 32'(error), 1);
        end else begin
            if (cnt == 8'd0) check("zero_latency", 32'(it), 1);
            check("done_flag", 32'(done), 1);
            check("done_error", 32'(error), 0);
            check("done_busy", 32'(busy), 0);
            check("done_code", 32'(error_code), 0);
            check("done_written", 32'(blocks_written), 32'(cnt));
            check("done_strobes", 32'(obs_n), 32'(exp_q.size()));
        end
    endtask

    initial begin
        reset = 1;
        start = 0;
        base_block = 0;
        block_count = 0;
        drive_busy = 0;
        block_write_interrupt = 0;
        write_completion_interrupt = 0;
        write_interface_error = 0;
        write_crc_error = 0;
        repeat (3) @(posedge clock);
        check_quiet("reset");
        reset = 0;
        repeat (2) @(posedge clock);
        check_quiet("idle");

        run(32'h0000_0000, 8'd1, 0, -1, 0, -1, 0);
        run(32'hFFFF_FFFE, 8'd3, 0, -1, 0, -1, 0);
        run($urandom, 8'd2, 1, 100, 0, -1, 0);
        run($urandom, 8'd1, 2, $urandom_range(0, 511), 0, -1, 0);
        run($urandom, 8'd1, 3, 5, 0, -1, 0);
        run($urandom, 8'd1, 0, -1, 1, -1, 0);
        run($urandom, 8'd0, 0, -1, 0, -1, 0);
        run($urandom, 8'd2, 0, -1, 0, -1, 1);
        run(32'h1234_5678, 8'd1, 0, -1, 0, $urandom_range(0, 511), 0);
        check_quiet("after_reset");
        run(32'h1234_5678, 8'd2, 0, -1, 0, -1, 0);
        repeat (2) run($urandom, 8'($urandom_range(1, 2)), 0, -1, 0, -1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/kfmmc_block_write_sequencer.md
# kfmmc_block_write_sequencer

Host-side sequencer that writes a run of 512-byte blocks to the card through the KFMMC_Drive register interface, generating a deterministic byte pattern per block. It is the write-direction counterpart of the block-read demo flow. It sits between a demo/test top (start, status) and KFMMC_Drive (address strobes, command strobe, byte strobes, interrupts). A later read-back pass can verify the card contents against the same pattern.

## Interface
Parameters:
- WRITE_COMMAND, 8'hC0, byte placed on internal_data_bus during write_access_command
- SEED, 8'h5A, pattern seed
- TIMEOUT, 32'h000FFFF0, negedge-clock cycles allowed in any wait state before error

Ports:
- clock  in  1  sequencer clock; all state updates on negedge
- reset  in  1  asynchronous, active-high
- start  in  1  begin run; sampled in IDLE, DONE, ERROR only
- base_block  in  32  first block number, latched at start
- block_count  in  8  number of blocks, latched at start
- busy  out  1  high in every state except IDLE, DONE, ERROR
- done  out  1  high in DONE
- error  out  1  high in ERROR
- error_code  out  2  01 interface, 10 CRC, 11 timeout, 00 none
- blocks_written  out  8  completed blocks in current run
- internal_data_bus  out  8  address/command/data byte to drive
- write_block_address_1..4  out  1 each  address byte strobes (1 = bits 7:0 … 4 = bits 31:24)
- write_access_command  out  1  command strobe
- write_data  out  1  data byte strobe
- drive_busy  in  1  drive not ready for a new command
- block_write_interrupt  in  1  drive requests next data byte
- write_completion_interrupt  in  1  block programmed
- write_interface_error  in  1  drive reports interface/response error
- write_crc_error  in  1  drive reports data CRC rejection

## Operation
- Strobes and internal_data_bus are Moore outputs decoded from state; each strobe high for exactly one clock; bus 8'h00 when no strobe.
- States: IDLE, WAIT_READY, ADDR_1, ADDR_2, ADDR_3, ADDR_4, COMMAND, WAIT_REQ, SEND_BYTE, WAIT_COMPLETE, NEXT_BLOCK, DONE, ERROR.
- IDLE/DONE/ERROR + start: latch base_block, block_count; clear blocks_written, error_code, byte_index; go WAIT_READY, or DONE if block_count == 0.
- WAIT_READY: ~drive_busy -> ADDR_1.
- ADDR_1..ADDR_4: bus = current_block byte 0..3, matching strobe; advance one per clock; ADDR_4 -> COMMAND.
- COMMAND: bus = WRITE_COMMAND, write_access_command = 1 -> WAIT_REQ.
- WAIT_REQ: block_write_interrupt -> SEND_BYTE.
- SEND_BYTE: bus = byte_index[7:0] ^ current_block[7:0] ^ SEED, write_data = 1; byte_index++; if byte_index was 511 -> WAIT_COMPLETE else WAIT_REQ.
- WAIT_COMPLETE: write_completion_interrupt -> NEXT_BLOCK.
- NEXT_BLOCK: blocks_written++, current_block++ (32-bit wrap, FFFFFFFF -> 00000000), byte_index = 0; blocks_written == block_count -> DONE, else WAIT_READY.
- Errors: write_interface_error or write_crc_error high in any busy state -> ERROR; CRC takes priority in error_code if both. Error check overrides every other transition in the same cycle.
- Timeout: 32-bit counter cleared on each state change, increments in WAIT_READY, WAIT_REQ, WAIT_COMPLETE; reaching TIMEOUT -> ERROR, code 11.
- DONE and ERROR hold until start or reset; start while busy ignored.

## Timing
- Reset: state IDLE; busy, done, error, all strobes 0; error_code 00; blocks_written 0; internal_data_bus 00.
- Start at negedge n with drive idle: ADDR_1 at n+1, COMMAND at n+5, first WAIT_REQ at n+6.
- Each data byte: one clock in SEND_BYTE after the request is seen; minimum two clocks per byte (WAIT_REQ, SEND_BYTE). Interrupt held high re-arms only after return to WAIT_REQ.
- Completion and request interrupts arriving simultaneously in WAIT_REQ after byte 511: not possible by protocol; completion ignored outside WAIT_COMPLETE.
- blocks_written visible one clock after NEXT_BLOCK; done asserted same edge DONE entered.
- Reset mid-block: immediate return to IDLE, strobes drop asynchronously, no further bus activity.

## Test plan
- block_count=1, base_block=0, drive model requests 512 bytes -> strobes address 00,00,00,00, command C0, bytes 5A,5B,58,…; done=1, blocks_written=1.
- block_count=3, base_block=FFFFFFFE -> address sequences FE/FF/FF/FF, FF/FF/FF/FF, 00/00/00/00; first byte of each block 5A^FE=A4, A5, 5A; done, blocks_written=3.
- write_crc_error pulsed during byte 100 of block 0 -> ERROR next edge, error_code=10, no further write_data.
- Drive never raises write_completion_interrupt, TIMEOUT=16 -> ERROR after 16 clocks in WAIT_COMPLETE, error_code=11.
- block_count=0 + start -> DONE next edge, no strobes; start again while busy in a 2-block run -> ignored, run completes normally.
- Reset asserted in SEND_BYTE -> all outputs reset values immediately; subsequent start runs cleanly from block base.
